// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-rate divider, x/y scan counters,
// registered sync pulses and visible-area / frame-boundary strobes.
module vga_sync #(
  parameter int DIV       = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_hsync;
  logic          r_vsync;

  logic          w_tick;
  logic          w_xwrap;
  logic [9:0]    w_x_nxt;
  logic [9:0]    w_y_nxt;

  // rst_n gating keeps p_tick low in reset even when DIV == 1
  always_comb begin
    w_tick  = rst_n && (r_div == DIV_MAX);
    w_xwrap = (r_x >= H_MAX);
    w_x_nxt = w_xwrap ? 10'd0 : r_x + 10'd1;
    w_y_nxt = r_y;
    if ((r_y > V_MAX) || (w_xwrap && (r_y == V_MAX))) begin
      w_y_nxt = 10'd0;
    end else if (w_xwrap) begin
      w_y_nxt = r_y + 10'd1;
    end
  end

  // syncs decode the next counter values so they land on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_div <= (r_div >= DIV_MAX) ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_hsync <= !((w_x_nxt >= HS_BEG) && (w_x_nxt <= HS_END));
        r_vsync <= !((w_y_nxt >= VS_BEG) && (w_y_nxt <= VS_END));
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign p_tick      = w_tick;
  assign video_on    = (r_x < H_VIS) && (r_y < V_VIS);
  assign frame_start = w_tick && (r_x == H_MAX) && (r_y == V_MAX);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default-timing instance plus a shrunken DIV=2
// instance, both checked every cycle against an arithmetic raster model.
module tb_vga_sync;

  localparam int S_DIV = 2;
  localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VD = 6, S_VF = 2, S_VS = 2, S_VB = 3;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       fs;
  } out_t;

  typedef struct {
    int   n;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   edges = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [9:0] x_d, y_d, x_s, y_s;
  logic hs_d, vs_d, von_d, pt_d, fs_d;
  logic hs_s, vs_s, von_s, pt_s, fs_s;
  out_t od, os;

  assign od = {x_d, y_d, hs_d, vs_d, von_d, pt_d, fs_d};
  assign os = {x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s};

  always #5 clk = ~clk;

  vga_sync u_dflt (
    .clk(clk), .rst_n(rst_n), .x(x_d), .y(y_d),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d),
    .p_tick(pt_d), .frame_start(fs_d)
  );

  vga_sync #(
    .DIV(S_DIV),
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .x(x_s), .y(y_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .p_tick(pt_s), .frame_start(fs_s)
  );

  // clock edges seen since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic out_t mk(input int xx, input int yy, input bit hs,
                              input bit vs, input bit von, input bit pt,
                              input bit fs);
    out_t o;
    o.x = 10'(xx); o.y = 10'(yy);
    o.hs = hs; o.vs = vs; o.von = von; o.pt = pt; o.fs = fs;
    return o;
  endfunction

  function automatic out_t model(input int n, input bit in_rst,
                                 input int dv, input int hd, input int hf,
                                 input int hsw, input int hb, input int vd,
                                 input int vf, input int vsw, input int vb);
    int ht, vt, p, px, py;
    bit pt;
    if (in_rst) return mk(0, 0, 1, 1, 1, 0, 0);
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    p  = n / dv;
    px = p % ht;
    py = (p / ht) % vt;
    pt = (n % dv) == dv - 1;
    return mk(px, py,
              !(px >= hd + hf && px < hd + hf + hsw),
              !(py >= vd + vf && py < vd + vf + vsw),
              px < hd && py < vd,
              pt,
              pt && px == ht - 1 && py == vt - 1);
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b",
               name, edges, got.x, got.y, got.hs, got.vs, got.von, got.pt, got.fs,
               exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.pt, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_out("model_dflt", od,
                model(edges, !rst_n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      check_out("model_small", os,
                model(edges, !rst_n, S_DIV, S_HD, S_HF, S_HS, S_HB,
                      S_VD, S_VF, S_VS, S_VB));
    end
  end

  vec_t tbl[12];
  out_t rst_vals;
  int   guard;
  int   hs_low, first_hs, first_von, vs_low, max_x, max_y;
  int   fs_at[$];

  initial begin
    tbl[0]  = '{0,    mk(0,   0, 1, 1, 1, 0, 0)};
    tbl[1]  = '{2,    mk(0,   0, 1, 1, 1, 0, 0)};
    tbl[2]  = '{3,    mk(0,   0, 1, 1, 1, 1, 0)};
    tbl[3]  = '{4,    mk(1,   0, 1, 1, 1, 0, 0)};
    tbl[4]  = '{7,    mk(1,   0, 1, 1, 1, 1, 0)};
    tbl[5]  = '{8,    mk(2,   0, 1, 1, 1, 0, 0)};
    tbl[6]  = '{2560, mk(640, 0, 1, 1, 0, 0, 0)};
    tbl[7]  = '{2624, mk(656, 0, 0, 1, 0, 0, 0)};
    tbl[8]  = '{3007, mk(751, 0, 0, 1, 0, 1, 0)};
    tbl[9]  = '{3008, mk(752, 0, 1, 1, 0, 0, 0)};
    tbl[10] = '{3199, mk(799, 0, 1, 1, 0, 1, 0)};
    tbl[11] = '{3200, mk(0,   1, 1, 1, 1, 0, 0)};
    rst_vals = mk(0, 0, 1, 1, 1, 0, 0);

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1 check_out("reset_dflt", od, rst_vals);
    check_out("reset_small", os, rst_vals);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      guard = 0;
      while (edges < tbl[i].n && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      check_int("tbl_reach", edges, tbl[i].n);
      check_out("tbl", od, tbl[i].exp);
    end

    // line y=1 of the default instance: sync width and blanking start
    hs_low = 0; first_hs = -1; first_von = -1;
    for (int k = 0; k < 3200; k++) begin
      if (k > 0) @(negedge clk);
      if (!hs_d) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(x_d);
      end
      if (!von_d && first_von < 0) first_von = int'(x_d);
    end
    @(negedge clk);
    check_int("hsync_low_clks", hs_low, 384);
    check_int("hsync_first_x", first_hs, 656);
    check_int("video_off_x", first_von, 640);
    check_out("line_wrap", od, mk(0, 2, 1, 1, 1, 0, 0));

    // asynchronous reset mid-line at x=300
    guard = 0;
    while (edges < 7601 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check_out("pre_async_x300", od, mk(300, 2, 1, 1, 1, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("async_dflt", od, rst_vals);
    check_out("async_small", os, rst_vals);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_out("restart", od, mk((k == 4) ? 1 : 0, 0, 1, 1, 1, k == 3, 0));
    end

    // four frames of the small DIV=2 instance
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    vs_low = 0; max_x = 0; max_y = 0;
    for (int k = 0; k < 1560; k++) begin
      @(negedge clk);
      if (fs_s) begin
        fs_at.push_back(edges);
        check_out("fs_pos", os, mk(14, 12, 1, 1, 0, 1, 1));
      end
      if (!vs_s) vs_low++;
      if (int'(x_s) > max_x) max_x = int'(x_s);
      if (int'(y_s) > max_y) max_y = int'(y_s);
    end
    check_int("fs_count", fs_at.size(), 4);
    if (fs_at.size() == 4) begin
      check_int("fs_first", fs_at[0], 389);
      for (int i = 1; i < 4; i++)
        check_int("fs_period", fs_at[i] - fs_at[i-1], 390);
    end
    check_int("vsync_low_clks", vs_low, 240);
    check_int("max_x", max_x, 14);
    check_int("max_y", max_y, 12);

    // random reset assertions and releases, off the clock edges
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 600)) @(posedge clk);
      #($urandom_range(1, 4)) rst_n = 1'b0;
      #1 check_out("rand_rst_dflt", od, rst_vals);
      check_out("rand_rst_small", os, rst_vals);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #($urandom_range(1, 4)) rst_n = 1'b1;
    end
    repeat (400) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter DIV, default 4, gives system clocks per pixel tick (100 MHz to 25 MHz).
REQ-002 Parameter H_DISPLAY, default 640, gives visible pixels per line.
REQ-003 Parameter H_FRONT, default 16, gives the horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, default 96, gives the horizontal sync width in pixels.
REQ-005 Parameter H_BACK, default 48, gives the horizontal back porch in pixels.
REQ-006 Parameter V_DISPLAY, default 480, gives visible lines per frame.
REQ-007 Parameter V_FRONT, default 10, gives the vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 2, gives the vertical sync width in lines.
REQ-009 Parameter V_BACK, default 33, gives the vertical back porch in lines.
REQ-010 clk  input  1  system clock; all state changes on its rising edge.
REQ-011 rst_n  input  1  asynchronous, active-low reset.
REQ-012 x  output  10  current pixel column, feeding the character and object renderers.
REQ-013 y  output  10  current pixel row, feeding the character and object renderers.
REQ-014 hsync  output  1  horizontal sync, active low.
REQ-015 vsync  output  1  vertical sync, active low.
REQ-016 video_on  output  1  high while (x, y) is inside the visible area.
REQ-017 p_tick  output  1  one-clk pulse marking each pixel advance.
REQ-018 frame_start  output  1  one-clk pulse marking the last pixel of a frame.

Function
REQ-019 The divider counter SHALL count 0..DIV-1 and wrap to 0; p_tick SHALL be high exactly in the clk cycle where the divider equals DIV-1.
REQ-020 H_TOTAL SHALL be H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL be V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-021 The x counter SHALL increment on the clk edge that ends a p_tick cycle, wrapping from H_TOTAL-1 to 0, and SHALL hold at all other times.
REQ-022 The y counter SHALL increment only on the edge where x wraps, wrapping from V_TOTAL-1 to 0; a simultaneous x and y wrap SHALL yield (0,0) in one edge.
REQ-023 x and y SHALL be driven directly from the counter registers, with no combinational path from any input.
REQ-024 hsync SHALL be a register low exactly while x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751], updated on the same edge as x so it is cycle-aligned with x.
REQ-025 vsync SHALL be a register low exactly while y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491], aligned with y.
REQ-026 video_on SHALL equal (x < H_DISPLAY) && (y < V_DISPLAY), decoded from the registered counters.
REQ-027 frame_start SHALL be high exactly in the clk cycle where p_tick=1, x=H_TOTAL-1 and y=V_TOTAL-1.
REQ-028 The counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1; any out-of-range value SHALL wrap to 0 on the next pixel advance.
REQ-029 The frame period SHALL be exactly DIV*H_TOTAL*V_TOTAL clk cycles (1,680,000 at defaults).

Reset
REQ-030 While rst_n=0, the block SHALL hold divider=0, x=0, y=0, hsync=1, vsync=1, p_tick=0, frame_start=0 and video_on=1, taking effect immediately without a clk edge.
REQ-031 Asserting rst_n mid-frame SHALL abandon the frame; after release, the first p_tick SHALL occur in the DIV-th clk cycle, and x SHALL become 1 on the edge that ends it.
REQ-032 Reset release SHALL be accepted on any clk edge; no output SHALL glitch to a non-reset value while rst_n=0.

Verification
REQ-033 Reset, then release, then 4 clks -> p_tick is high only in cycle 4 and x=1 after cycle 4; x stays 0 in cycles 1-3.
REQ-034 Run one line (3200 clks) -> hsync is low for exactly 384 clks starting at x=656; video_on is low from x=640; x returns to 0 with y=1.
REQ-035 Run a full frame -> vsync is low for exactly 2 lines (y=490,491); frame_start pulses once, at x=799, y=524; the next state is (0,0).
REQ-036 Assert rst_n=0 asynchronously at x=300, y=200, between clk edges -> all outputs reach reset values before the next edge; restart matches REQ-033.
REQ-037 Run 3 consecutive frames -> frame_start pulses are exactly 1,680,000 clks apart; x never exceeds 799 and y never exceeds 524.
REQ-038 Parameter override DIV=2 -> p_tick occurs every 2 clks and the frame period is 840,000 clks.
